// File: rtl/bus_b_pkg.sv
// Shared widths, source indices and FSM encoding for the registered bus-B source mux.
package bus_b_pkg;

    localparam int DATA_W   = 16;
    localparam int SEL_W    = 4;
    localparam int NARROW_W = 8;
    localparam int N_SRC    = 9;

    localparam int SRC_RAM   = 0;
    localparam int SRC_PC    = 1;
    localparam int SRC_R1    = 2;
    localparam int SRC_R2    = 3;
    localparam int SRC_TR    = 4;
    localparam int SRC_R     = 5;
    localparam int SRC_AC    = 6;
    localparam int SRC_INSTR = 7;
    localparam int SRC_AR    = 8;

    // RAM data byte and instruction byte are the narrow sources by default
    localparam logic [N_SRC-1:0] NARROW_MASK = 9'b0_1000_0001;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

endpackage

// File: rtl/bus_src_select.sv
// Combinational N_SRC-to-1 source select with per-source zero-extension and range flag.
module bus_src_select #(
    parameter int                  DATA_W      = bus_b_pkg::DATA_W,
    parameter int                  N_SRC       = bus_b_pkg::N_SRC,
    parameter int                  SEL_W       = bus_b_pkg::SEL_W,
    parameter int                  NARROW_W    = bus_b_pkg::NARROW_W,
    parameter logic [N_SRC-1:0]    NARROW_MASK = bus_b_pkg::NARROW_MASK
) (
    input  logic [N_SRC*DATA_W-1:0] src_in,
    input  logic [SEL_W-1:0]        sel,
    output logic [DATA_W-1:0]       data,
    output logic                    in_range
);

    import bus_b_pkg::*;

    localparam logic [DATA_W-1:0] NARROW_KEEP = DATA_W'({NARROW_W{1'b1}});

    // An unmatched index leaves the output at zero, so nothing is ever undriven
    always_comb begin
        data     = '0;
        in_range = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                in_range = 1'b1;
                if (NARROW_MASK[i])
                    data = src_in[i*DATA_W +: DATA_W] & NARROW_KEEP;
                else
                    data = src_in[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/bus_b_source_mux.sv
// Registered bus-B source multiplexer: sticky selection, HOLD freeze, explicit release.
module bus_b_source_mux #(
    parameter int                  DATA_W      = bus_b_pkg::DATA_W,
    parameter int                  N_SRC       = bus_b_pkg::N_SRC,
    parameter int                  SEL_W       = bus_b_pkg::SEL_W,
    parameter int                  NARROW_W    = bus_b_pkg::NARROW_W,
    parameter logic [N_SRC-1:0]    NARROW_MASK = bus_b_pkg::NARROW_MASK
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic [N_SRC*DATA_W-1:0] SRC_IN,
    input  logic [SEL_W-1:0]        SELECT,
    input  logic                    SEL_VALID,
    input  logic                    HOLD,
    input  logic                    RELEASE,
    output logic [DATA_W-1:0]       BUS,
    output logic                    BUS_VALID,
    output logic [SEL_W-1:0]        CUR_SEL,
    output logic                    SEL_ERR
);

    import bus_b_pkg::*;

    state_t              state;
    logic [DATA_W-1:0]   req_data;
    logic [DATA_W-1:0]   cur_data;
    logic                req_in_range;
    logic                cur_in_range;
    logic                take_sel;

    // One selector for the incoming request, one for the source already owned
    bus_src_select #(
        .DATA_W      (DATA_W),
        .N_SRC       (N_SRC),
        .SEL_W       (SEL_W),
        .NARROW_W    (NARROW_W),
        .NARROW_MASK (NARROW_MASK)
    ) u_req_sel (
        .src_in   (SRC_IN),
        .sel      (SELECT),
        .data     (req_data),
        .in_range (req_in_range)
    );

    bus_src_select #(
        .DATA_W      (DATA_W),
        .N_SRC       (N_SRC),
        .SEL_W       (SEL_W),
        .NARROW_W    (NARROW_W),
        .NARROW_MASK (NARROW_MASK)
    ) u_cur_sel (
        .src_in   (SRC_IN),
        .sel      (CUR_SEL),
        .data     (cur_data),
        .in_range (cur_in_range)
    );

    assign take_sel = SEL_VALID && req_in_range;

    // SEL_ERR is evaluated regardless of RELEASE/HOLD so a dropped bad select is still reported
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            BUS       <= '0;
            BUS_VALID <= 1'b0;
            CUR_SEL   <= '0;
            SEL_ERR   <= 1'b0;
        end else begin
            SEL_ERR <= SEL_VALID && !req_in_range;
            if (RELEASE) begin
                state     <= ST_IDLE;
                BUS       <= '0;
                BUS_VALID <= 1'b0;
            end else if (HOLD) begin
                state     <= state;
            end else if (take_sel) begin
                state     <= ST_DRIVE;
                CUR_SEL   <= SELECT;
                BUS       <= req_data;
                BUS_VALID <= 1'b1;
            end else if (state == ST_DRIVE && cur_in_range) begin
                BUS       <= cur_data;
                BUS_VALID <= 1'b1;
            end else begin
                state     <= ST_IDLE;
                BUS       <= '0;
                BUS_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: doc/bus_b_source_mux.md
Name: bus_b_source_mux

Overview:
- Parametrised, registered successor to the combinational bus-B source multiplexer of the datapath.
- Selects one of N_SRC source registers (PC, R1, R2, TR, R, AC, AR, instruction byte, RAM data byte by default) onto bus B through a one-cycle registered stage.
- Selection is sticky across cycles, out-of-range selects are flagged instead of latched, and a HOLD freeze and explicit bus release are provided.
- Sits between the register file / memory interface and the ALU B-operand / bus-B consumers; driven by the control unit.

Parameters:
- DATA_W, 16, bus width in bits.
- N_SRC, 9, number of sources; source i occupies SRC_IN[i*DATA_W +: DATA_W].
- SEL_W, 4, select width; must satisfy 2**SEL_W >= N_SRC.
- NARROW_W, 8, width of narrow sources.
- NARROW_MASK, 9'b0_1000_0001, bit i set means source i is narrow: only its low NARROW_W bits are used and the upper bits are zero-extended.

Ports:
- CLOCK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- SRC_IN  input  N_SRC*DATA_W  flattened source vector.
- SELECT  input  SEL_W  requested source index.
- SEL_VALID  input  1  SELECT is sampled on this cycle.
- HOLD  input  1  freeze BUS at its current value.
- RELEASE  input  1  drop bus ownership and return to IDLE.
- BUS  output  DATA_W  registered bus value.
- BUS_VALID  output  1  BUS carries a selected source.
- CUR_SEL  output  SEL_W  index of the currently owned source.
- SEL_ERR  output  1  one-cycle pulse on an out-of-range select.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - BUS=0, BUS_VALID=0, CUR_SEL=0, SEL_ERR=0, state=IDLE.
  - SRC_IN values are not captured during reset.
- FSM, two states:
  - IDLE: BUS=0, BUS_VALID=0.
  - DRIVE: BUS tracks the selected source, BUS_VALID=1.
- Valid select (SEL_VALID=1 and SELECT<N_SRC) at edge k:
  - At edge k: CUR_SEL<=SELECT, state<=DRIVE, BUS<=extend(SRC_IN[SELECT]).
  - Latency is one cycle: new data is visible after edge k.
- In DRIVE with no new select:
  - Each edge reloads BUS from SRC_IN[CUR_SEL], so BUS follows the live source with one-cycle delay.
  - Selection is sticky until a new valid select or RELEASE.
- Invalid select (SEL_VALID=1 and SELECT>=N_SRC):
  - SEL_ERR=1 for exactly one cycle.
  - State, CUR_SEL and BUS behave as if no select occurred. The bus is never left undriven and no latch is inferred.
- Zero-extension: a narrow source yields {(DATA_W-NARROW_W) zeros, low NARROW_W bits}. Upper source bits are ignored.
- HOLD=1: BUS, CUR_SEL and state are frozen.
  - A valid select arriving during HOLD is discarded, not queued.
  - An invalid select during HOLD still pulses SEL_ERR.
- RELEASE=1: at the next edge, state<=IDLE, BUS<=0, BUS_VALID<=0. CUR_SEL retains its value.
- Priority on the same edge: RESET > RELEASE > HOLD > valid select > track.
  - RELEASE with SEL_VALID: release wins and the select is dropped.
  - SEL_ERR is still generated if the dropped select was out of range.
- In IDLE with no valid select: BUS stays 0. HOLD in IDLE has no visible effect.
- Back-to-back valid selects on consecutive cycles: each takes effect on its own edge, with no bubble.

Decomposition:
- Shared package bus_b_pkg holds:
  - DATA_W, SEL_W, NARROW_W;
  - source index constants SRC_RAM=0, SRC_PC=1, SRC_R1=2, SRC_R2=3, SRC_TR=4, SRC_R=5, SRC_AC=6, SRC_INSTR=7, SRC_AR=8;
  - the default NARROW_MASK;
  - state encoding ST_IDLE=0, ST_DRIVE=1.
- One sub-module, bus_src_select: combinational N_SRC-to-1 select with per-source zero-extension and an in_range output. The top module holds the FSM, the BUS/CUR_SEL registers and SEL_ERR.

Test Plan:
- Reset → registers idle: assert RESET mid-cycle while in DRIVE with BUS=16'h1080 → BUS=0, BUS_VALID=0, CUR_SEL=0 immediately, without waiting for a clock edge.
- Select PC with zero-extension: PC=16'h1080, SELECT=1 with SEL_VALID → next edge BUS=16'h1080, BUS_VALID=1, CUR_SEL=1. Then select 0 with RAM=16'hAB55 → BUS=16'h0055.
- Sticky tracking: after selecting AC (6), change AC 16'h00C0→16'h1234 with no select → BUS=16'h1234 one edge later.
- Invalid select: SELECT=4'd12 with SEL_VALID while driving R1=16'h0880 → SEL_ERR high for one cycle, BUS stays 16'h0880, CUR_SEL=2.
- HOLD: HOLD=1 while driving TR=16'h0280, then TR→16'hFFFF and SELECT=8 → BUS remains 16'h0280 and CUR_SEL=4. After HOLD drops, BUS=16'hFFFF one edge later.
- RELEASE vs select: RELEASE=1 and SEL_VALID with SELECT=3 on the same edge → BUS=0, BUS_VALID=0, CUR_SEL unchanged. A following select of 7 with INSTR=8'h77 → BUS=16'h0077.
